// File: rtl/mprf_wbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mprf_wbuf                                                       |
// | Purpose  : Multi-port register file with an in-order write-back buffer.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mprf_wbuf #(
   parameter int XLEN      = 32,
   parameter int RGNUM     = 32,
   parameter int RGBIT     = 5,
   parameter int WR_PORTS  = 4,
   parameter int RD_PORTS  = 8,
   parameter int BUF_DEPTH = 8,
   parameter int CNT_W     = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           direct_mode,
   input  logic                           flush,
   input  logic                           mem_release,
   input  logic [RGBIT-1:0]               mem_sel,
   input  logic [XLEN-1:0]                mem_data,
   input  logic [WR_PORTS*RGBIT-1:0]      wr_sel,
   input  logic [WR_PORTS*CNT_W-1:0]      wr_cnt,
   input  logic [WR_PORTS*XLEN-1:0]       wr_data,
   input  logic [RD_PORTS*RGBIT-1:0]      rd_sel,
   output logic [RD_PORTS*XLEN-1:0]       rd_data,
   output logic [$clog2(WR_PORTS+1)-1:0]  rf_release,
   output logic [$clog2(BUF_DEPTH+1)-1:0] buf_space,
   output logic                           buf_ovf
);
   localparam int C_REL_W = $clog2(WR_PORTS+1);
   localparam int C_LEN_W = $clog2(BUF_DEPTH+1);
   localparam int C_SEL_N = 2**RGBIT;

   logic [XLEN-1:0]    r_rf       [RGNUM];
   logic [RGBIT-1:0]   r_buf_sel  [BUF_DEPTH];
   logic [CNT_W-1:0]   r_buf_cnt  [BUF_DEPTH];
   logic [XLEN-1:0]    r_buf_data [BUF_DEPTH];
   logic [C_LEN_W-1:0] r_buf_len;
   logic [C_LEN_W-1:0] r_buf_space;
   logic               r_buf_ovf;

   logic [RGBIT-1:0]   w_lane_sel  [WR_PORTS];
   logic [CNT_W-1:0]   w_lane_cnt  [WR_PORTS];
   logic [CNT_W-1:0]   w_lane_eff  [WR_PORTS];
   logic [XLEN-1:0]    w_lane_data [WR_PORTS];
   logic [CNT_W-1:0]   w_buf_eff   [BUF_DEPTH];
   logic [BUF_DEPTH-1:0] w_commit;
   logic [BUF_DEPTH-1:0] w_keep;
   logic [C_SEL_N-1:0] w_blocked;
   logic [C_REL_W-1:0] w_rel;
   logic [RGBIT-1:0]   w_nxt_sel  [BUF_DEPTH];
   logic [CNT_W-1:0]   w_nxt_cnt  [BUF_DEPTH];
   logic [XLEN-1:0]    w_nxt_data [BUF_DEPTH];
   logic [C_LEN_W-1:0] w_nxt_len;
   logic               w_ovf;
   int                 w_fill;

   for (genvar l = 0; l < WR_PORTS; l++) begin : g_lane
      assign w_lane_sel[l]  = wr_sel[l*RGBIT +: RGBIT];
      assign w_lane_cnt[l]  = wr_cnt[l*CNT_W +: CNT_W];
      assign w_lane_data[l] = wr_data[l*XLEN +: XLEN];
      assign w_lane_eff[l]  = (mem_release && w_lane_cnt[l] != '0) ?
                              w_lane_cnt[l] - CNT_W'(1) : w_lane_cnt[l];
   end

   for (genvar i = 0; i < BUF_DEPTH; i++) begin : g_eff
      assign w_buf_eff[i] = (mem_release && r_buf_cnt[i] != '0) ?
                            r_buf_cnt[i] - CNT_W'(1) : r_buf_cnt[i];
   end

   // Any retained entry blocks younger entries of the same register (WAW order).
   always_comb begin
      w_commit  = '0;
      w_keep    = '0;
      w_blocked = '0;
      w_rel     = '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
         if (i < int'(r_buf_len) && !direct_mode) begin
            if (w_buf_eff[i] == '0 && r_buf_sel[i] != '0 &&
                !w_blocked[r_buf_sel[i]] && int'(w_rel) < WR_PORTS) begin
               w_commit[i] = 1'b1;
               w_rel       = w_rel + C_REL_W'(1);
            end else begin
               w_blocked[r_buf_sel[i]] = 1'b1;
               w_keep[i] = !(flush && w_buf_eff[i] != '0);
            end
         end
      end
   end

   always_comb begin
      w_fill = 0;
      w_ovf  = 1'b0;
      for (int j = 0; j < BUF_DEPTH; j++) begin
         w_nxt_sel[j]  = '0;
         w_nxt_cnt[j]  = '0;
         w_nxt_data[j] = '0;
      end
      for (int i = 0; i < BUF_DEPTH; i++) begin
         if (w_keep[i] && w_fill < BUF_DEPTH) begin
            w_nxt_sel[w_fill]  = r_buf_sel[i];
            w_nxt_cnt[w_fill]  = w_buf_eff[i];
            w_nxt_data[w_fill] = r_buf_data[i];
            w_fill             = w_fill + 1;
         end
      end
      for (int l = 0; l < WR_PORTS; l++) begin
         if (!direct_mode && w_lane_sel[l] != '0 && !(flush && w_lane_cnt[l] != '0)) begin
            if (w_fill < BUF_DEPTH) begin
               w_nxt_sel[w_fill]  = w_lane_sel[l];
               w_nxt_cnt[w_fill]  = w_lane_eff[l];
               w_nxt_data[w_fill] = w_lane_data[l];
               w_fill             = w_fill + 1;
            end else begin
               w_ovf = 1'b1;
            end
         end
      end
      w_nxt_len = direct_mode ? r_buf_len : C_LEN_W'(w_fill);
   end

   // Later writes in each loop override earlier ones; the mem write goes last.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < RGNUM; r++) r_rf[r] <= '0;
         for (int j = 0; j < BUF_DEPTH; j++) begin
            r_buf_sel[j]  <= '0;
            r_buf_cnt[j]  <= '0;
            r_buf_data[j] <= '0;
         end
         r_buf_len   <= '0;
         r_buf_space <= C_LEN_W'(BUF_DEPTH);
         r_buf_ovf   <= 1'b0;
      end else begin
         if (direct_mode) begin
            for (int l = 0; l < WR_PORTS; l++)
               if (w_lane_sel[l] != '0 && int'(w_lane_sel[l]) < RGNUM)
                  r_rf[w_lane_sel[l]] <= w_lane_data[l];
         end else begin
            for (int i = 0; i < BUF_DEPTH; i++)
               if (w_commit[i] && int'(r_buf_sel[i]) < RGNUM)
                  r_rf[r_buf_sel[i]] <= r_buf_data[i];
            for (int j = 0; j < BUF_DEPTH; j++) begin
               r_buf_sel[j]  <= w_nxt_sel[j];
               r_buf_cnt[j]  <= w_nxt_cnt[j];
               r_buf_data[j] <= w_nxt_data[j];
            end
            r_buf_len <= w_nxt_len;
         end
         if (mem_sel != '0 && int'(mem_sel) < RGNUM)
            r_rf[mem_sel] <= mem_data;
         r_buf_space <= C_LEN_W'(BUF_DEPTH) - w_nxt_len;
         if (w_ovf) r_buf_ovf <= 1'b1;
      end
   end

   for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
      logic [RGBIT-1:0] w_sel;
      logic [XLEN-1:0]  w_val;
      assign w_sel = rd_sel[p*RGBIT +: RGBIT];
      always_comb begin
         w_val = '0;
         if (w_sel != '0 && int'(w_sel) < RGNUM) w_val = r_rf[w_sel];
         for (int i = 0; i < BUF_DEPTH; i++)
            if (i < int'(r_buf_len) && w_sel != '0 && r_buf_sel[i] == w_sel)
               w_val = r_buf_data[i];
      end
      assign rd_data[p*XLEN +: XLEN] = w_val;
   end

   assign rf_release = w_rel;
   assign buf_space  = r_buf_space;
   assign buf_ovf    = r_buf_ovf;
endmodule
`default_nettype wire

// File: tb/tb_mprf_wbuf.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mprf_wbuf                                                    |
// | Purpose  : Vector table plus directed sequences for mprf_wbuf.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mprf_wbuf;
   localparam int XLEN = 32;
   localparam int RGBIT = 5;
   localparam int WP = 4;
   localparam int RP = 8;
   localparam int CW = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              direct_mode, flush, mem_release;
   logic [RGBIT-1:0]  mem_sel;
   logic [XLEN-1:0]   mem_data;
   logic [WP*RGBIT-1:0] wr_sel;
   logic [WP*CW-1:0]  wr_cnt;
   logic [WP*XLEN-1:0] wr_data;
   logic [RP*RGBIT-1:0] rd_sel;
   logic [RP*XLEN-1:0] rd_data;
   logic [2:0]        rf_release;
   logic [3:0]        buf_space;
   logic              buf_ovf;

   mprf_wbuf dut (
      .clk(clk), .rst(rst), .direct_mode(direct_mode), .flush(flush),
      .mem_release(mem_release), .mem_sel(mem_sel), .mem_data(mem_data),
      .wr_sel(wr_sel), .wr_cnt(wr_cnt), .wr_data(wr_data), .rd_sel(rd_sel),
      .rd_data(rd_data), .rf_release(rf_release), .buf_space(buf_space),
      .buf_ovf(buf_ovf)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [WP-1:0][RGBIT-1:0] sel;
      logic [WP-1:0][XLEN-1:0]  data;
      logic                     direct;
      int                       rel;
   } vec_t;

   typedef struct {
      string           name;
      int              r;
      logic [XLEN-1:0] v;
   } exp_t;

   vec_t tbl[6];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      wr_sel = '0; wr_cnt = '0; wr_data = '0;
      direct_mode = 1'b0; flush = 1'b0; mem_release = 1'b0;
      mem_sel = '0; mem_data = '0;
   endtask

   task automatic lane(input int l, input int sel, input int cnt, input logic [XLEN-1:0] d);
      wr_sel[l*RGBIT +: RGBIT] = RGBIT'(sel);
      wr_cnt[l*CW +: CW]       = CW'(cnt);
      wr_data[l*XLEN +: XLEN]  = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic rd_chk(input string name, input int r, input logic [XLEN-1:0] exp);
      rd_sel[0 +: RGBIT] = RGBIT'(r);
      #1;
      check(name, 64'(rd_data[0 +: XLEN]), 64'(exp));
   endtask

   function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                               input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                               input logic [XLEN-1:0] d2, input logic [XLEN-1:0] d3,
                               input logic dir, input int rel);
      vec_t v;
      v.sel[0] = RGBIT'(s0); v.sel[1] = RGBIT'(s1);
      v.sel[2] = RGBIT'(s2); v.sel[3] = RGBIT'(s3);
      v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
      v.direct = dir;
      v.rel = rel;
      return v;
   endfunction

   // Pushes one expectation per destination; a later lane to the same register wins.
   task automatic run_row(input int r);
      bit   shadowed;
      exp_t e;
      idle();
      direct_mode = tbl[r].direct;
      for (int l = 0; l < WP; l++) begin
         lane(l, int'(tbl[r].sel[l]), 0, tbl[r].data[l]);
         if (tbl[r].sel[l] != '0) begin
            shadowed = 1'b0;
            for (int m = l + 1; m < WP; m++)
               if (tbl[r].sel[m] == tbl[r].sel[l]) shadowed = 1'b1;
            if (!shadowed) begin
               e.name = $sformatf("row%0d x%0d", r, tbl[r].sel[l]);
               e.r    = int'(tbl[r].sel[l]);
               e.v    = tbl[r].data[l];
               sb.push_back(e);
            end
         end
      end
      settle();
      check($sformatf("row%0d arrival release", r), 64'(rf_release), 64'(0));
      tick();
      idle();
      settle();
      check($sformatf("row%0d release", r), 64'(rf_release), 64'(tbl[r].rel));
      tick();
      settle();
      check($sformatf("row%0d space", r), 64'(buf_space), 64'(8));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         rd_chk(e.name, e.r, e.v);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = mk(1, 2, 3, 4, 32'h100, 32'h200, 32'h300, 32'h400, 1'b0, 4);
      tbl[1] = mk(6, 0, 6, 0, 32'h61, 32'h0, 32'h62, 32'h0, 1'b0, 2);
      tbl[2] = mk(0, 0, 0, 31, 32'h0, 32'h0, 32'h0, 32'h1F1F, 1'b0, 1);
      tbl[3] = mk(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
      tbl[4] = mk(9, 9, 9, 9, 32'h91, 32'h92, 32'h93, 32'h94, 1'b0, 4);
      tbl[5] = mk(20, 21, 20, 0, 32'hD0, 32'hD1, 32'hD2, 32'h0, 1'b1, 0);

      idle();
      rd_sel = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset space", 64'(buf_space), 64'(8));
      check("reset ovf", 64'(buf_ovf), 64'(0));
      check("reset release", 64'(rf_release), 64'(0));
      rst = 1'b1;
      rd_chk("reset x5", 5, 32'h0);

      // Single cnt=0 lane: bypass after one edge, array after two.
      tick();
      lane(0, 5, 0, 32'hA5);
      settle();
      check("t1 arrival release", 64'(rf_release), 64'(0));
      tick();
      idle();
      rd_chk("t1 bypass x5", 5, 32'hA5);
      check("t1 release", 64'(rf_release), 64'(1));
      check("t1 space", 64'(buf_space), 64'(7));
      tick();
      check("t1 release after", 64'(rf_release), 64'(0));
      check("t1 space after", 64'(buf_space), 64'(8));
      rd_chk("t1 array x5", 5, 32'hA5);

      for (int r = 0; r < 6; r++) run_row(r);

      // Outstanding count of two.
      lane(0, 3, 2, 32'h33);
      tick();
      idle();
      settle();
      check("t2 held release", 64'(rf_release), 64'(0));
      check("t2 space", 64'(buf_space), 64'(7));
      tick();
      rd_chk("t2 bypass x3", 3, 32'h33);
      mem_release = 1'b1;
      settle();
      check("t2 first release", 64'(rf_release), 64'(0));
      tick();
      settle();
      check("t2 second release", 64'(rf_release), 64'(1));
      tick();
      mem_release = 1'b0;
      settle();
      check("t2 space after", 64'(buf_space), 64'(8));
      rd_chk("t2 array x3", 3, 32'h33);

      // WAW: older x7 cnt=2, younger x7 cnt=0.
      lane(0, 7, 2, 32'h71);
      lane(1, 7, 0, 32'h72);
      tick();
      idle();
      settle();
      check("t3 younger held", 64'(rf_release), 64'(0));
      rd_chk("t3 bypass x7", 7, 32'h72);
      mem_release = 1'b1;
      settle();
      check("t3 held first release", 64'(rf_release), 64'(0));
      tick();
      settle();
      check("t3 both commit", 64'(rf_release), 64'(2));
      rd_chk("t3 bypass x7 late", 7, 32'h72);
      tick();
      mem_release = 1'b0;
      settle();
      check("t3 space", 64'(buf_space), 64'(8));
      rd_chk("t3 array x7", 7, 32'h72);

      // Mem write beats a commit to the same register.
      lane(0, 4, 0, 32'h22);
      tick();
      idle();
      mem_sel = 5'd4;
      mem_data = 32'h11;
      settle();
      check("t5 release", 64'(rf_release), 64'(1));
      tick();
      idle();
      rd_chk("t5 x4", 4, 32'h11);

      // Fill, overflow, flush.
      for (int l = 0; l < WP; l++) lane(l, 10 + l, 3, 32'h1000 + 32'(l));
      tick();
      for (int l = 0; l < WP; l++) lane(l, 14 + l, 3, 32'h1400 + 32'(l));
      tick();
      idle();
      settle();
      check("t4 full space", 64'(buf_space), 64'(0));
      check("t4 no ovf yet", 64'(buf_ovf), 64'(0));
      rd_chk("t4 x17", 17, 32'h1403);
      lane(0, 18, 3, 32'h18);
      lane(1, 19, 3, 32'h19);
      tick();
      idle();
      settle();
      check("t4 ovf", 64'(buf_ovf), 64'(1));
      check("t4 space", 64'(buf_space), 64'(0));
      rd_chk("t4 dropped x18", 18, 32'h0);
      rd_chk("t4 x10", 10, 32'h1000);
      flush = 1'b1;
      settle();
      check("t4 flush release", 64'(rf_release), 64'(0));
      tick();
      idle();
      settle();
      check("t4 flushed space", 64'(buf_space), 64'(8));
      check("t4 ovf kept", 64'(buf_ovf), 64'(1));
      rd_chk("t4 flushed x10", 10, 32'h0);
      tick();
      check("t4 ovf sticky", 64'(buf_ovf), 64'(1));

      // Asynchronous reset with five entries buffered.
      for (int l = 0; l < WP; l++) lane(l, 1 + l, 3, 32'hE0 + 32'(l));
      tick();
      idle();
      lane(0, 5, 3, 32'hE5);
      tick();
      idle();
      settle();
      check("t6 space before", 64'(buf_space), 64'(3));
      #2;
      rst = 1'b0;
      #1;
      rd_sel = {5'd31, 5'd9, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
      #1;
      for (int p = 0; p < RP; p++)
         check($sformatf("t6 rd port%0d", p), 64'(rd_data[p*XLEN +: XLEN]), 64'(0));
      check("t6 space", 64'(buf_space), 64'(8));
      check("t6 ovf", 64'(buf_ovf), 64'(0));
      check("t6 release", 64'(rf_release), 64'(0));
      #3;
      rst = 1'b1;
      tick();
      check("t6 space after", 64'(buf_space), 64'(8));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
